pipeline_sequencer: RTL and testbench

//   Central sequencer for the 5-stage pipeline (fetch/decode/execution/memory/WB).

---
 rtl/pipeline_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Central sequencer for the 5-stage pipeline (fetch/decode/execution/memory/WB).
// Drives PC select/write, per-stage register enables, decode flush and execution
// bubble. Handles program load, load-use stalls, taken-branch flush and the
// DMEM wait-state freeze with an optional timeout into a sticky error state.
// Optional feature macro: PIPE_PERF_CNT_EN enables the stall/flush performance
// counters; without it both counter outputs are tied to zero.
module pipeline_sequencer #(
  parameter int LOAD_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             SYS_load,
  input  logic [7:0]       SYS_pc_val,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic             D_uses_rt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_write_register,
  input  logic             EX_branch_taken,
  input  logic             MEM_req,
  input  logic             MEM_ready,
  output logic             PC_write,
  output logic [1:0]       PC_sel,
  output logic [31:0]      PC_load_val,
  output logic             D_write,
  output logic             EX_write,
  output logic             MEM_write,
  output logic             WB_write,
  output logic             D_flush,
  output logic             EX_bubble,
  output logic [2:0]       ctl_state,
  output logic             ctl_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RUN      = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  localparam int LC_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [LC_W-1:0] LOAD_LAST = LC_W'(LOAD_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(MEM_TIMEOUT - 1);

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_LOAD   = 2'b10;

  state_t          state, state_nxt;
  logic [LC_W-1:0] load_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            load_first;
  logic            load_use;
  logic            frozen;
  logic            timeout_hit;

  // Down-counter starts at LOAD_LAST, so the first LOAD cycle is the PC-load cycle.
  assign load_first = (load_cnt == LOAD_LAST);

  assign load_use = EX_MemRead && (EX_write_register != 5'd0) &&
                    ((EX_write_register == D_rs) ||
                     (D_uses_rt && (EX_write_register == D_rt)));

  // RUN freezes only on an outstanding DMEM request; MEM_WAIT holds until ready.
  assign frozen = (state == S_MEM_WAIT) ? !MEM_ready : (MEM_req && !MEM_ready);

  // The counter holds the number of MEM_WAIT cycles already spent; the last allowed one trips.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (to_cnt == TO_LAST);

  assign ctl_state = state;

  // Next-state and output decode; SYS_load overrides any pending freeze or stall.
  always_comb begin
    state_nxt = state;
    PC_write  = 1'b0;
    PC_sel    = PC_SEL_SEQ;
    D_write   = 1'b0;
    EX_write  = 1'b0;
    MEM_write = 1'b0;
    WB_write  = 1'b0;
    D_flush   = 1'b0;
    EX_bubble = 1'b0;
    case (state)
      S_IDLE, S_ERROR: state_nxt = state;
      S_LOAD: begin
        {D_write, EX_write, MEM_write, WB_write} = 4'hF;
        D_flush   = 1'b1;
        EX_bubble = 1'b1;
        if (load_first) begin
          PC_sel   = PC_SEL_LOAD;
          PC_write = 1'b1;
        end
        if (load_cnt == '0) state_nxt = S_RUN;
      end
      S_RUN, S_MEM_WAIT: begin
        if (frozen) begin
          if (state == S_RUN) state_nxt = S_MEM_WAIT;
          else if (timeout_hit) state_nxt = S_ERROR;
        end else begin
          state_nxt = S_RUN;
          if (EX_branch_taken) begin
            PC_sel    = PC_SEL_BRANCH;
            PC_write  = 1'b1;
            {D_write, EX_write, MEM_write, WB_write} = 4'hF;
            D_flush   = 1'b1;
            EX_bubble = 1'b1;
          end else if (load_use) begin
            {D_write, EX_write, MEM_write, WB_write} = 4'b0111;
            EX_bubble = 1'b1;
          end else begin
            PC_write  = 1'b1;
            {D_write, EX_write, MEM_write, WB_write} = 4'hF;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (SYS_load) state_nxt = S_LOAD;
  end

  // State register.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // LOAD duration down-counter, re-armed on every SYS_load.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset)                              load_cnt <= '0;
    else if (SYS_load)                          load_cnt <= LOAD_LAST;
    else if (state == S_LOAD && load_cnt != '0) load_cnt <= load_cnt - 1'b1;
  end

  // Consecutive MEM_WAIT cycle counter; cleared whenever the wait is not ongoing.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset)
      to_cnt <= '0;
    else if (SYS_load || state != S_MEM_WAIT || MEM_ready)
      to_cnt <= '0;
    else if (!timeout_hit && MEM_TIMEOUT != 0)
      to_cnt <= to_cnt + 1'b1;
  end

  // Captured program start address.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset)     PC_load_val <= 32'd0;
    else if (SYS_load) PC_load_val <= {22'b0, SYS_pc_val, 2'b00};
  end

  // Sticky timeout flag, cleared only by a new program load.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset)                  ctl_error <= 1'b0;
    else if (SYS_load)              ctl_error <= 1'b0;
    else if (state_nxt == S_ERROR)  ctl_error <= 1'b1;
  end

`ifdef PIPE_PERF_CNT_EN
  logic             stall_evt, flush_evt, run_like;
  logic [CNT_W-1:0] stall_q, flush_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign run_like  = (state == S_RUN) || (state == S_MEM_WAIT);
  assign stall_evt = run_like && !SYS_load && (frozen || (!EX_branch_taken && load_use));
  assign flush_evt = run_like && !SYS_load && !frozen && EX_branch_taken;

  // Saturating stall/flush performance counters.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt) stall_q <= sat_inc(stall_q);
      if (flush_evt) flush_q <= sat_inc(flush_q);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus a
// randomized run, all compared against an in-bench behavioural model.
`timescale 1ns/1ps
module tb_pipeline_sequencer;
  localparam int LOAD_CYCLES = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             SYS_clk;
  logic             SYS_reset, SYS_load;
  logic [7:0]       SYS_pc_val;
  logic [4:0]       D_rs, D_rt, EX_write_register;
  logic             D_uses_rt, EX_MemRead, EX_branch_taken, MEM_req, MEM_ready;
  logic             PC_write, D_write, EX_write, MEM_write, WB_write, D_flush, EX_bubble, ctl_error;
  logic [1:0]       PC_sel;
  logic [31:0]      PC_load_val;
  logic [2:0]       ctl_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_sequencer #(.LOAD_CYCLES(LOAD_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .SYS_load(SYS_load), .SYS_pc_val(SYS_pc_val),
    .D_rs(D_rs), .D_rt(D_rt), .D_uses_rt(D_uses_rt), .EX_MemRead(EX_MemRead),
    .EX_write_register(EX_write_register), .EX_branch_taken(EX_branch_taken),
    .MEM_req(MEM_req), .MEM_ready(MEM_ready), .PC_write(PC_write), .PC_sel(PC_sel),
    .PC_load_val(PC_load_val), .D_write(D_write), .EX_write(EX_write), .MEM_write(MEM_write),
    .WB_write(WB_write), .D_flush(D_flush), .EX_bubble(EX_bubble), .ctl_state(ctl_state),
    .ctl_error(ctl_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  int checks = 0;
  int passed = 0;

  // Behavioural model: mode 0 idle, 1 load, 2 run, 3 mem wait, 4 error.
  int          m_mode, m_load_age, m_wait, m_stalls, m_flushes;
  bit          m_err;
  logic [31:0] m_pcv;
  bit          e_pcw, e_fl, e_bub, e_frozen, inc_st, inc_fl;
  logic [1:0]  e_sel;
  logic [3:0]  e_en;

  typedef logic [52:0] vec_t;

  function automatic vec_t obs_vec();
    return {PC_write, PC_sel, D_write, EX_write, MEM_write, WB_write, D_flush, EX_bubble,
            ctl_state, ctl_error, PC_load_val, stall_cnt, flush_cnt};
  endfunction

  function automatic int clamp(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic model_eval();
    bit hz, active;
    e_pcw = 0; e_sel = 2'b00; e_en = 4'h0; e_fl = 0; e_bub = 0;
    e_frozen = 0; inc_st = 0; inc_fl = 0;
    hz = EX_MemRead && (EX_write_register != 0) &&
         ((EX_write_register == D_rs) || (D_uses_rt && (EX_write_register == D_rt)));
    case (m_mode)
      1: begin
        e_en = 4'hF; e_fl = 1; e_bub = 1;
        if (m_load_age == 0) begin e_sel = 2'b10; e_pcw = 1; end
      end
      2, 3: begin
        active = (m_mode == 2) ? !(MEM_req && !MEM_ready) : MEM_ready;
        if (!active) begin e_frozen = 1; inc_st = 1; end
        else if (EX_branch_taken) begin
          e_sel = 2'b01; e_pcw = 1; e_en = 4'hF; e_fl = 1; e_bub = 1; inc_fl = 1;
        end else if (hz) begin
          e_en = 4'b0111; e_bub = 1; inc_st = 1;
        end else begin
          e_pcw = 1; e_en = 4'hF;
        end
      end
      default: ;
    endcase
  endtask

  function automatic vec_t exp_vec();
    logic [CNT_W-1:0] s, f;
    s = PERF ? CNT_W'(clamp(m_stalls))  : '0;
    f = PERF ? CNT_W'(clamp(m_flushes)) : '0;
    return {e_pcw, e_sel, e_en, e_fl, e_bub, 3'(m_mode), m_err, m_pcv, s, f};
  endfunction

  task automatic model_update();
    if (SYS_reset) begin
      m_mode = 0; m_load_age = 0; m_wait = 0; m_stalls = 0; m_flushes = 0; m_err = 0; m_pcv = '0;
    end else if (SYS_load) begin
      m_mode = 1; m_load_age = 0; m_wait = 0; m_err = 0; m_pcv = {22'b0, SYS_pc_val, 2'b00};
    end else begin
      m_stalls  += int'(inc_st);
      m_flushes += int'(inc_fl);
      case (m_mode)
        1: begin m_load_age++; if (m_load_age == LOAD_CYCLES) m_mode = 2; end
        2: if (e_frozen) m_mode = 3;
        3: begin
          if (MEM_ready) begin m_mode = 2; m_wait = 0; end
          else begin
            m_wait++;
            if (MEM_TIMEOUT != 0 && m_wait == MEM_TIMEOUT) begin m_mode = 4; m_err = 1; m_wait = 0; end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge SYS_clk);
    model_eval();
    model_update();
    @(negedge SYS_clk);
  endtask

  task automatic quiet();
    SYS_load = 0; SYS_pc_val = 8'h00; D_rs = 0; D_rt = 0; D_uses_rt = 0; EX_MemRead = 0;
    EX_write_register = 0; EX_branch_taken = 0; MEM_req = 0; MEM_ready = 0;
  endtask

  task automatic test_reset();
    quiet(); SYS_reset = 1; SYS_load = 1; SYS_pc_val = 8'hAB; MEM_req = 1; EX_branch_taken = 1;
    tick(); tick();
    quiet(); SYS_reset = 0;
    #1; model_eval();
    checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset_vec: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    checks++;
    if (ctl_state !== 3'd0 || PC_load_val !== 32'd0 || ctl_error !== 1'b0 || PC_write !== 1'b0)
      $display("FAIL reset_regs: state=%0d pcv=%h err=%b pcw=%b want 0/0/0/0", ctl_state, PC_load_val, ctl_error, PC_write);
    else passed++;
    tick();
  endtask

  task automatic test_load();
    quiet(); SYS_load = 1; SYS_pc_val = 8'h10;
    #1; model_eval();
    checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL load_req: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    tick();
    quiet();
    for (int i = 0; i < LOAD_CYCLES; i++) begin
      #1; model_eval();
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL load_vec c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      checks++;
      if (D_flush !== 1'b1 || ctl_state !== 3'd1 || PC_sel !== ((i == 0) ? 2'b10 : 2'b00) || PC_write !== (i == 0))
        $display("FAIL load_ctl c%0d: flush=%b state=%0d sel=%b pcw=%b", i, D_flush, ctl_state, PC_sel, PC_write);
      else passed++;
      tick();
    end
    #1;
    checks++;
    if (ctl_state !== 3'd2 || PC_load_val !== 32'h40)
      $display("FAIL load_done: state=%0d pcv=%h want 2/00000040", ctl_state, PC_load_val);
    else passed++;
  endtask

  task automatic test_load_use();
    logic       rd_t [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] wr_t [5] = '{5'd0, 5'd7, 5'd7, 5'd9, 5'd12};
    logic [4:0] rs_t [5] = '{5'd0, 5'd2, 5'd2, 5'd9, 5'd12};
    logic [4:0] rt_t [5] = '{5'd0, 5'd7, 5'd7, 5'd9, 5'd3};
    logic       ur_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       st_t [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    quiet(); EX_MemRead = 1; EX_write_register = 5'd5; D_rs = 5'd5;
    #1; model_eval();
    checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL lu_vec: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    checks++;
    if (PC_write !== 1'b0 || D_write !== 1'b0 || EX_bubble !== 1'b1 || EX_write !== 1'b1)
      $display("FAIL lu_ctl: pcw=%b dw=%b bub=%b exw=%b want 0/0/1/1", PC_write, D_write, EX_bubble, EX_write);
    else passed++;
    tick();
    quiet();
    #1;
    checks++;
    if (stall_cnt !== (PERF ? 4'd1 : 4'd0)) $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, PERF ? 1 : 0);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      quiet();
      EX_MemRead = rd_t[i]; EX_write_register = wr_t[i]; D_rs = rs_t[i]; D_rt = rt_t[i]; D_uses_rt = ur_t[i];
      #1; model_eval();
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL lu_tab_vec %0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      checks++;
      if (PC_write !== !st_t[i] || D_write !== !st_t[i] || EX_bubble !== st_t[i])
        $display("FAIL lu_tab %0d: pcw=%b dw=%b bub=%b stall_expected=%b", i, PC_write, D_write, EX_bubble, st_t[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_branch();
    quiet(); EX_branch_taken = 1; EX_MemRead = 1; EX_write_register = 5'd4; D_rs = 5'd4;
    #1; model_eval();
    checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL br_vec: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    checks++;
    if (PC_sel !== 2'b01 || PC_write !== 1'b1 || D_flush !== 1'b1 || EX_bubble !== 1'b1 || D_write !== 1'b1)
      $display("FAIL br_ctl: sel=%b pcw=%b flush=%b bub=%b dw=%b want 01/1/1/1/1", PC_sel, PC_write, D_flush, EX_bubble, D_write);
    else passed++;
    tick();
    quiet();
    #1; model_eval();
    checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL br_after: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    checks++;
    if (flush_cnt !== (PERF ? 4'd1 : 4'd0)) $display("FAIL br_cnt: got %0d want %0d", flush_cnt, PERF ? 1 : 0);
    else passed++;
    tick();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 4; i++) begin
      quiet(); MEM_req = 1; MEM_ready = (i == 3);
      #1; model_eval();
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL mw_vec c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      checks++;
      if ({D_write, EX_write, MEM_write, WB_write, PC_write} !== ((i == 3) ? 5'h1F : 5'h00) ||
          ctl_state !== ((i == 0) ? 3'd2 : 3'd3))
        $display("FAIL mw_ctl c%0d: en=%b%b%b%b pcw=%b state=%0d", i, D_write, EX_write, MEM_write, WB_write, PC_write, ctl_state);
      else passed++;
      tick();
    end
    quiet();
    #1;
    checks++;
    if (ctl_state !== 3'd2) $display("FAIL mw_exit: state=%0d want 2", ctl_state);
    else passed++;
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 6; i++) begin
      quiet(); MEM_req = 1; MEM_ready = 0;
      #1; model_eval();
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL to_vec c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
    quiet();
    #1;
    checks++;
    if (ctl_state !== 3'd4 || ctl_error !== 1'b1 || {D_write, EX_write, MEM_write, WB_write, PC_write} !== 5'h00)
      $display("FAIL to_err: state=%0d err=%b pcw=%b want 4/1/0", ctl_state, ctl_error, PC_write);
    else passed++;
    tick();
    SYS_load = 1; SYS_pc_val = 8'h03;
    #1; model_eval();
    checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL to_load_req: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    tick();
    quiet();
    #1;
    checks++;
    if (ctl_state !== 3'd1 || ctl_error !== 1'b0 || PC_load_val !== 32'h0000000C)
      $display("FAIL to_clear: state=%0d err=%b pcv=%h want 1/0/0000000c", ctl_state, ctl_error, PC_load_val);
    else passed++;
    for (int i = 0; i < LOAD_CYCLES; i++) begin
      model_eval();
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL to_reload c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      tick();
      #1;
    end
  endtask

  task automatic test_reset_in_wait();
    for (int i = 0; i < 2; i++) begin
      quiet(); MEM_req = 1; MEM_ready = 0;
      #1; model_eval();
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL rw_vec c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
    #1;
    checks++;
    if (ctl_state !== 3'd3) $display("FAIL rw_wait: state=%0d want 3", ctl_state);
    else passed++;
    SYS_reset = 1; SYS_load = 1; MEM_ready = 1;
    #1;
    tick();
    quiet(); SYS_reset = 0;
    #1; model_eval();
    checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL rw_reset_vec: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    checks++;
    if (ctl_state !== 3'd0 || PC_load_val !== 32'd0 || stall_cnt !== '0 || flush_cnt !== '0 ||
        {D_write, EX_write, MEM_write, WB_write, PC_write, D_flush, EX_bubble} !== 7'h00)
      $display("FAIL rw_reset: state=%0d pcv=%h stall=%0d flush=%0d", ctl_state, PC_load_val, stall_cnt, flush_cnt);
    else passed++;
    tick();
  endtask

  task automatic test_random();
    quiet(); SYS_load = 1; SYS_pc_val = 8'h21;
    #1;
    tick();
    for (int n = 0; n < 600; n++) begin
      quiet();
      SYS_reset         = ($urandom_range(0, 199) == 0);
      SYS_load          = ($urandom_range(0, 39) == 0);
      SYS_pc_val        = 8'($urandom);
      D_rs              = 5'($urandom_range(0, 3));
      D_rt              = 5'($urandom_range(0, 3));
      D_uses_rt         = 1'($urandom_range(0, 1));
      EX_MemRead        = ($urandom_range(0, 2) == 0);
      EX_write_register = 5'($urandom_range(0, 3));
      EX_branch_taken   = ($urandom_range(0, 5) == 0);
      MEM_req           = ($urandom_range(0, 3) == 0);
      MEM_ready         = 1'($urandom_range(0, 1));
      #1; model_eval();
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL rand_vec n%0d: got %h want %h", n, obs_vec(), exp_vec());
      else passed++;
      tick();
    end
    SYS_reset = 0;
  endtask

  initial begin
    quiet(); SYS_reset = 1;
    test_reset();
    test_load();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
